// File: rtl/postproc_pipe.sv
// Two-stage requantization datapath: residual add, round-half-up, saturate, optional ReLU.
// Build option: define POSTPROC_RESIDUAL_EN to enable the identity (residual) add path.
module postproc_pipe #(
  parameter int BW_ACC = 24,
  parameter int BW_IDT = 8,
  parameter int BW_OUT = 8,
  parameter int BW_FL  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*BW_ACC-1:0]   psum,
  input  logic [4*BW_IDT-1:0]   idt,
  input  logic [BW_FL-1:0]      residual_shift_ch0,
  input  logic [BW_FL-1:0]      residual_shift_ch1,
  input  logic [BW_FL-1:0]      residual_shift_ch2,
  input  logic [BW_FL-1:0]      residual_shift_ch3,
  input  logic [BW_FL-1:0]      quantizer_shift_ch0,
  input  logic [BW_FL-1:0]      quantizer_shift_ch1,
  input  logic [BW_FL-1:0]      quantizer_shift_ch2,
  input  logic [BW_FL-1:0]      quantizer_shift_ch3,
  input  logic                  relu_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*BW_OUT-1:0]   out_data,
  input  logic                  sat_clr,
  output logic [15:0]           sat_cnt
);

  localparam int SW = BW_ACC + 1;
  localparam int RW = BW_ACC + 2;
  localparam logic signed [RW-1:0] SAT_MAX = RW'((2 ** (BW_OUT - 1)) - 1);
  localparam logic signed [RW-1:0] SAT_MIN = RW'(-(2 ** (BW_OUT - 1)));

  // Handshake: a beat moves on a side when valid && ready are both high at the rising edge.
  logic out_en;
  logic s1_en;

  logic                   s1_v_q, s1_v_d;
  logic signed [SW-1:0]   s1_sum_q [4];
  logic signed [SW-1:0]   s1_sum_d [4];
  logic [BW_FL-1:0]       s1_qs_q  [4];
  logic [BW_FL-1:0]       s1_qs_d  [4];
  logic                   s1_relu_q, s1_relu_d;

  logic                   out_valid_q, out_valid_d;
  logic [4*BW_OUT-1:0]    out_data_q, out_data_d;
  logic [15:0]            sat_cnt_q, sat_cnt_d;

  logic [BW_FL-1:0]       qs_in  [4];
  logic signed [SW-1:0]   sum_w  [4];

  assign qs_in[0] = quantizer_shift_ch0;
  assign qs_in[1] = quantizer_shift_ch1;
  assign qs_in[2] = quantizer_shift_ch2;
  assign qs_in[3] = quantizer_shift_ch3;

`ifdef POSTPROC_RESIDUAL_EN
  logic [BW_FL-1:0]       rs_in   [4];
  logic signed [SW-1:0]   idt_ext [4];
  logic signed [SW-1:0]   idt_sh  [4];

  assign rs_in[0] = residual_shift_ch0;
  assign rs_in[1] = residual_shift_ch1;
  assign rs_in[2] = residual_shift_ch2;
  assign rs_in[3] = residual_shift_ch3;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      idt_ext[i] = SW'(signed'(idt[(3-i)*BW_IDT +: BW_IDT]));
      idt_sh[i]  = (int'(rs_in[i]) >= SW) ? '0 : (idt_ext[i] << rs_in[i]);
      sum_w[i]   = SW'(signed'(psum[(3-i)*BW_ACC +: BW_ACC])) + idt_sh[i];
    end
  end
`else
  logic unused_residual;
  assign unused_residual = ^{idt, residual_shift_ch0, residual_shift_ch1,
                             residual_shift_ch2, residual_shift_ch3};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sum_w[i] = SW'(signed'(psum[(3-i)*BW_ACC +: BW_ACC]));
    end
  end
`endif

  assign out_en   = !out_valid_q || out_ready;
  assign s1_en    = !s1_v_q || out_en;
  assign in_ready = s1_en;

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_relu_d = s1_relu_q;
    for (int i = 0; i < 4; i++) begin
      s1_sum_d[i] = s1_sum_q[i];
      s1_qs_d[i]  = s1_qs_q[i];
    end
    if (s1_en) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_relu_d = relu_en;
        for (int i = 0; i < 4; i++) begin
          s1_sum_d[i] = sum_w[i];
          s1_qs_d[i]  = qs_in[i];
        end
      end
    end
  end

  logic signed [SW-1:0]     q_w   [4];
  logic signed [RW-1:0]     r_w   [4];
  logic signed [BW_OUT-1:0] res_w [4];
  logic                     sat_w [4];
  logic [2:0]               n_sat;
  logic [16:0]              cnt_sum;

  // The quantizer shift leaves one extra fractional bit, consumed by (q+1)>>>1.
  always_comb begin
    n_sat = '0;
    for (int i = 0; i < 4; i++) begin
      if (int'(s1_qs_q[i]) >= BW_ACC) begin
        q_w[i] = {SW{s1_sum_q[i][SW-1]}};
      end else begin
        q_w[i] = s1_sum_q[i] >>> s1_qs_q[i];
      end
      r_w[i] = (RW'(q_w[i]) + RW'(1)) >>> 1;
      sat_w[i] = 1'b0;
      if (r_w[i] > SAT_MAX) begin
        res_w[i] = BW_OUT'(SAT_MAX);
        sat_w[i] = 1'b1;
      end else if (r_w[i] < SAT_MIN) begin
        res_w[i] = BW_OUT'(SAT_MIN);
        sat_w[i] = 1'b1;
      end else begin
        res_w[i] = BW_OUT'(r_w[i]);
      end
      if (s1_relu_q && res_w[i][BW_OUT-1]) begin
        res_w[i] = '0;
      end
      n_sat = n_sat + 3'(sat_w[i]);
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (out_en) begin
      out_valid_d = s1_v_q;
      if (s1_v_q) begin
        for (int i = 0; i < 4; i++) begin
          out_data_d[(3-i)*BW_OUT +: BW_OUT] = res_w[i];
        end
      end
    end
  end

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    cnt_sum   = {1'b0, sat_cnt_q} + 17'(n_sat);
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (out_en && s1_v_q) begin
      sat_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q      <= 1'b0;
      s1_relu_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_cnt_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        s1_sum_q[i] <= '0;
        s1_qs_q[i]  <= '0;
      end
    end else begin
      s1_v_q      <= s1_v_d;
      s1_relu_q   <= s1_relu_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sat_cnt_q   <= sat_cnt_d;
      for (int i = 0; i < 4; i++) begin
        s1_sum_q[i] <= s1_sum_d[i];
        s1_qs_q[i]  <= s1_qs_d[i];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_postproc_pipe.sv
// Bench for postproc_pipe: directed vectors plus randomized streams against an integer model.
module tb_postproc_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] psum;
  logic [31:0] idt;
  logic [4:0]  rs_a [4];
  logic [4:0]  qs_a [4];
  logic        relu_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        sat_clr;
  logic [15:0] sat_cnt;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];
  int          exp_sat = 0;
  logic [31:0] mon_d;
  int          mon_n;

  postproc_pipe dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .psum                (psum),
    .idt                 (idt),
    .residual_shift_ch0  (rs_a[0]),
    .residual_shift_ch1  (rs_a[1]),
    .residual_shift_ch2  (rs_a[2]),
    .residual_shift_ch3  (rs_a[3]),
    .quantizer_shift_ch0 (qs_a[0]),
    .quantizer_shift_ch1 (qs_a[1]),
    .quantizer_shift_ch2 (qs_a[2]),
    .quantizer_shift_ch3 (qs_a[3]),
    .relu_en             (relu_en),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_data            (out_data),
    .sat_clr             (sat_clr),
    .sat_cnt             (sat_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: plain integer arithmetic on each channel
  function automatic logic [7:0] model_ch(input logic signed [23:0] p,
                                          input logic signed [7:0] id,
                                          input int rs, input int qs,
                                          input bit relu, output bit sat);
    longint s, sh, q, r;
    sh = 0;
`ifdef POSTPROC_RESIDUAL_EN
    if (rs < 25) sh = longint'(id) * (longint'(1) << rs);
`endif
    s = longint'(p) + sh;
    s = s & longint'(33554431);
    if (s >= 16777216) s = s - 33554432;
    if (qs >= 24) q = (s < 0) ? -1 : 0;
    else          q = s >>> qs;
    r = (q + 1) >>> 1;
    sat = 1'b0;
    if (r > 127) begin
      r = 127;
      sat = 1'b1;
    end else if (r < -128) begin
      r = -128;
      sat = 1'b1;
    end
    if (relu && r < 0) r = 0;
    return 8'(r);
  endfunction

  function automatic void model_beat(output logic [31:0] d, output int nsat);
    bit s;
    nsat = 0;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      d[(3-i)*8 +: 8] = model_ch(signed'(psum[(3-i)*24 +: 24]), signed'(idt[(3-i)*8 +: 8]),
                                 int'(rs_a[i]), int'(qs_a[i]), relu_en, s);
      nsat += int'(s);
    end
  endfunction

  // scoreboard collection: accepted beats go through the model, delivered beats are captured
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        model_beat(mon_d, mon_n);
        exp_q.push_back(mon_d);
        exp_sat = exp_sat + mon_n;
      end
      if (out_valid && out_ready) got_q.push_back(out_data);
    end
  end

  // driver tasks
  task automatic set_all(input int p, input int i_v, input int rs, input int qs, input bit relu);
    for (int i = 0; i < 4; i++) begin
      psum[(3-i)*24 +: 24] = 24'(p);
      idt[(3-i)*8 +: 8]    = 8'(i_v);
      rs_a[i] = 5'(rs);
      qs_a[i] = 5'(qs);
    end
    relu_en = relu;
  endtask

  task automatic set_random();
    for (int i = 0; i < 4; i++) begin
      psum[(3-i)*24 +: 24] = 24'($urandom);
      idt[(3-i)*8 +: 8]    = 8'($urandom);
      rs_a[i] = 5'($urandom_range(0, 31));
      qs_a[i] = 5'($urandom_range(0, 31));
    end
    relu_en = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_beat();
    int n = 0;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL drive_beat: in_ready stuck low, got %0b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [31:0] d);
    int n = 0;
    d = 'x;
    while (got_q.size() == 0 && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (got_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL wait_out: no output beat within 20 cycles");
    end else begin
      d = got_q.pop_front();
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
    set_all(0, 0, 0, 0, 1'b0);
    #3;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data: got %h required 0", out_data); end
    checks++; if (sat_cnt !== 16'h0) begin failures++; $display("FAIL reset_sat_cnt: got %0d required 0", sat_cnt); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_residual();
    logic [31:0] d;
    logic [31:0] e;
`ifdef POSTPROC_RESIDUAL_EN
    e = {4{8'd32}};
`else
    e = {4{8'd16}};
`endif
    clear_sb();
    set_all(256, 4, 6, 3, 1'b0);
    drive_beat();
    wait_out(d);
    checks++; if (d !== e) begin failures++; $display("FAIL residual_out: got %h required %h", d, e); end
    checks++; if (sat_cnt !== 16'd0) begin failures++; $display("FAIL residual_sat: got %0d required 0", sat_cnt); end
  endtask

  task automatic test_neg_round();
    logic [31:0] d;
    clear_sb();
    set_all(-3, 0, 0, 0, 1'b0);
    drive_beat();
    wait_out(d);
    checks++; if (d !== {4{8'hFF}}) begin failures++; $display("FAIL neg_round: got %h required ffffffff", d); end
    set_all(-3, 0, 0, 0, 1'b1);
    drive_beat();
    wait_out(d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL neg_round_relu: got %h required 0", d); end
  endtask

  task automatic test_saturation();
    logic [31:0] d;
    clear_sb();
    set_all(8388607, 0, 0, 0, 1'b0);
    drive_beat();
    wait_out(d);
    checks++; if (d !== {4{8'h7F}}) begin failures++; $display("FAIL sat_out1: got %h required 7f7f7f7f", d); end
    checks++; if (sat_cnt !== 16'd4) begin failures++; $display("FAIL sat_cnt1: got %0d required 4", sat_cnt); end
    drive_beat();
    wait_out(d);
    checks++; if (d !== {4{8'h7F}}) begin failures++; $display("FAIL sat_out2: got %h required 7f7f7f7f", d); end
    checks++; if (sat_cnt !== 16'd8) begin failures++; $display("FAIL sat_cnt2: got %0d required 8", sat_cnt); end
    sat_clr = 1'b1;
    drive_beat();
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    wait_out(d);
    checks++; if (d !== {4{8'h7F}}) begin failures++; $display("FAIL sat_out3: got %h required 7f7f7f7f", d); end
    checks++; if (sat_cnt !== 16'd0) begin failures++; $display("FAIL sat_clr: got %0d required 0", sat_cnt); end
  endtask

  task automatic test_large_shift();
    logic [31:0] d;
    clear_sb();
    set_all(-5, 100, 31, 31, 1'b0);
    drive_beat();
    wait_out(d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL qshift31: got %h required 0", d); end
    set_all(100, -7, 31, 1, 1'b0);
    drive_beat();
    wait_out(d);
    checks++; if (d !== {4{8'd25}}) begin failures++; $display("FAIL rshift31: got %h required 19191919", d); end
  endtask

  task automatic compare_queues(input string tag);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL %s_count: got %0d beats required %0d", tag, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s_data[%0d]: got %h required %h", tag, i, got_q[i], exp_q[i]);
      end
    end
    clear_sb();
  endtask

  task automatic test_back_to_back();
    clear_sb();
    out_ready = 1'b1;
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    exp_sat = 0;
    for (int b = 0; b < 40; b++) begin
      set_random();
      in_valid = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready[%0d]: got %0b required 1", b, in_ready); end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    compare_queues("b2b");
    checks++;
    if (int'(sat_cnt) !== exp_sat) begin
      failures++;
      $display("FAIL b2b_sat_cnt: got %0d required %0d", sat_cnt, exp_sat);
    end
  endtask

  task automatic test_backpressure();
    int occ = 0;
    bit stalled = 1'b0;
    logic [31:0] held = '0;
    bit exp_ir;
    clear_sb();
    fork
      begin
        for (int b = 0; b < 10; b++) begin
          set_random();
          drive_beat();
        end
      end
      begin
        for (int c = 0; c < 80; c++) begin
          out_ready = (c % 3 == 0);
          @(negedge clk);
          if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== held) begin
              failures++;
              $display("FAIL bp_hold[%0d]: got v=%0b %h required v=1 %h", c, out_valid, out_data, held);
            end
          end
          exp_ir = !(out_valid && !out_ready && occ == 2);
          checks++;
          if (in_ready !== exp_ir) begin
            failures++;
            $display("FAIL bp_in_ready[%0d]: got %0b required %0b", c, in_ready, exp_ir);
          end
          stalled = out_valid && !out_ready;
          held = out_data;
          occ = occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    compare_queues("bp");
  endtask

  task automatic test_async_reset();
    clear_sb();
    out_ready = 1'b0;
    set_all(8388607, 0, 0, 0, 1'b0);
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ar_full_in_ready: got %0b required 0", in_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ar_out_valid: got %0b required 0", out_valid); end
    checks++; if (sat_cnt !== 16'd0) begin failures++; $display("FAIL ar_sat_cnt: got %0d required 0", sat_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    clear_sb();
    set_all(256, 0, 0, 3, 1'b0);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ar_lat1: got %0b required 0", out_valid); end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== {4{8'd16}}) begin
      failures++;
      $display("FAIL ar_lat2: got v=%0b %h required v=1 10101010", out_valid, out_data);
    end
    @(posedge clk);
    #1;
    clear_sb();
  endtask

  task automatic test_sat_sticky();
    clear_sb();
    out_ready = 1'b1;
    set_all(-8388608, 0, 0, 0, 1'b0);
    in_valid = 1'b1;
    repeat (16400) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (sat_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_sticky: got %h required ffff", sat_cnt); end
    clear_sb();
  endtask

  initial begin
    test_reset();
    test_residual();
    test_neg_round();
    test_saturation();
    test_large_shift();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    test_sat_sticky();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/postproc_pipe.md
# postproc_pipe

Per-channel post-processing datapath for the zebranet accelerator. It consumes four-channel convolution partial sums plus the per-channel residual and quantizer shift amounts produced by the shift-amount controller. It then adds the aligned identity (residual) term, requantizes with round-half-up and saturation, and optionally applies ReLU. It sits between the PE-array accumulators and the output feature-map buffer, with a valid/ready handshake on both sides.

## Interface
- `BW_ACC`, 24: signed accumulator width per channel.
- `BW_IDT`, 8: signed identity width per channel.
- `BW_OUT`, 8: signed output width per channel.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block can accept the beat this cycle.
- `psum`  in  4*BW_ACC  signed partial sums, {ch0,ch1,ch2,ch3}, ch0 in the MSBs.
- `idt`  in  4*BW_IDT  signed identity values, same packing.
- `residual_shift_ch0..3`  in  `BW_FL` each  unsigned left shift applied to the identity.
- `quantizer_shift_ch0..3`  in  `BW_FL` each  unsigned arithmetic right shift before rounding.
- `relu_en`  in  1  clamp negative outputs to 0; sampled with the beat.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  4*BW_OUT  signed results, same packing.
- `sat_clr`  in  1  synchronous clear of `sat_cnt`.
- `sat_cnt`  out  16  saturation event counter.

## Operation
- **Stage 1 (S1 register).** On acceptance (`in_valid && in_ready`), per channel:
  - Compute `sum = sext(psum) + (sext(idt) << residual_shift)`, all in BW_ACC+1 signed bits.
  - The shifted identity is truncated to BW_ACC+1 bits; a shift of BW_ACC+1 or more yields 0.
  - Register `sum`, `quantizer_shift` and `relu_en` together with a valid bit `s1_v`.
- **Stage 2 (output register).** Per channel:
  - `q = sum >>> quantizer_shift`. A shift of BW_ACC or more gives sign fill (0 or -1).
  - `r = (q + 1) >>> 1`, computed in BW_ACC+2 bits. This is round-half-up; the quantizer shift already reserves one extra fractional bit for it.
  - Saturate `r` to [-2^(BW_OUT-1), 2^(BW_OUT-1)-1].
  - If `relu_en`, negative results become 0. Saturation is applied before ReLU.
- **Flow control.**
  - `out_en = !out_valid || out_ready`.
  - `s1_en = !s1_v || out_en`.
  - `in_ready = s1_en`, combinational with no skid buffer.
  - Bubbles collapse; no beat is dropped or duplicated.
- **Saturation counter.**
  - `sat_cnt` increments by the number of channels (0..4) that saturated in the beat being loaded into the output register.
  - It sticks at 0xFFFF and never wraps.
  - `sat_clr` takes priority: it clears the counter, and increments in the same cycle are discarded.
- **Shift inputs** are only required to be stable in the cycle the beat is accepted.

## Timing
- **Reset values:** `out_valid=0`, `out_data=0`, `sat_cnt=0`, `s1_v=0`. `in_ready` is 1 coming out of reset.
- **Latency:** 2 cycles. A beat accepted at edge k appears with `out_valid=1` after edge k+1.
- **Throughput:** 1 beat/cycle while `out_ready=1`.
- **Stall:** when `out_valid && !out_ready`, `out_data` holds stable. If S1 is also full, `in_ready` drops in the same cycle.
- **Simultaneous events:** when the output register is accepted and reloaded in the same cycle, the new beat replaces the old one without a gap.
- **Reset mid-operation:** both stages are flushed, and in-flight beats are lost.

## Configuration
- **`POSTPROC_RESIDUAL_EN` defined:** residual add as described above.
- **`POSTPROC_RESIDUAL_EN` undefined:**
  - `idt` and `residual_shift_ch*` are ignored.
  - `sum = sext(psum)`; no adder or shifter is instantiated.
  - Ports remain present and all other behaviour is identical.

## Test plan
- **Residual path:** psum ch0=256, idt=4, res_shift=6, q_shift=3, relu_en=0 -> ch0 out=32 two cycles later; sat_cnt=0.
- **Negative rounding:** psum=-3, idt=0, q_shift=0 -> out=-1. With relu_en=1 -> out=0.
- **Saturation:** psum=+8388607 on all 4 channels, q_shift=0 -> every channel out=127; sat_cnt=4. A second identical beat -> sat_cnt=8. `sat_clr` in the same cycle as a third beat -> sat_cnt=0.
- **Large shifts:** q_shift=31 with psum=-5 -> out=0, since (-1+1)>>>1=0. res_shift=31 -> identity contributes 0.
- **Backpressure:** stream 10 beats with out_ready toggling 1,0,0,1,... -> all 10 outputs arrive in order, no duplicates; out_data stays stable while stalled; in_ready=0 only when both stages are full.
- **Async reset mid-stream:** assert rst_n low between edges with 2 beats in flight -> out_valid=0 and sat_cnt=0 immediately. After release, the next accepted beat has latency 2.
